// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg : shared constants and channel-state encoding for clkdiv_multi
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clkdiv_pkg;

  localparam int CLKDIV_DEF_DIV  = 16;
  localparam int CLKDIV_DEF_HIGH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } ch_state_e;

  function automatic int ch_sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_channel.sv
// ---------------------------------------------------------------------------
// clkdiv_channel : one divider channel with shadowed div/high and glitch-free
//                  period-boundary updates (option CLKDIV_GLITCHFREE_STOP_EN)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int W        = 16,
  parameter int DEF_DIV  = CLKDIV_DEF_DIV,
  parameter int DEF_HIGH = CLKDIV_DEF_HIGH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic [W-1:0] wr_high,
  output logic         pending,
  output logic         out_clk,
  output logic         out_tick
);

  typedef struct packed {
    logic [W-1:0] div;
    logic [W-1:0] high;
  } cfg_t;

  localparam cfg_t CFG_RST = {W'(DEF_DIV), W'(DEF_HIGH)};

  ch_state_e    state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  cfg_t         act, act_nx, shd, shd_nx, ld;
  logic         pend_nx, clk_nx, tick_nx, wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      act      <= CFG_RST;
      shd      <= '0;
      pending  <= 1'b0;
      out_clk  <= 1'b0;
      out_tick <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      act      <= act_nx;
      shd      <= shd_nx;
      pending  <= pend_nx;
      out_clk  <= clk_nx;
      out_tick <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    act_nx   = act;
    shd_nx   = shd;
    pend_nx  = pending;
    clk_nx   = 1'b0;
    tick_nx  = 1'b0;
    ld       = pending ? shd : act;
    // div==0 never reaches RUN, but treat it as a wrap so a stray value cannot hang the counter
    wrap     = (act.div == '0) || (cnt >= act.div - 1'b1);

    case (state)
      ST_IDLE: begin
        act_nx  = ld;
        pend_nx = 1'b0;
        if (en && (ld.div != '0))
          state_nx = ST_RUN;
      end
      default: begin
        cnt_nx   = wrap ? '0 : cnt + 1'b1;
        state_nx = ST_RUN;
        if (wrap) begin
          act_nx  = ld;
          pend_nx = 1'b0;
        end
`ifdef CLKDIV_GLITCHFREE_STOP_EN
        if (!en)
          state_nx = wrap ? ST_IDLE : ST_STOPPING;
`else
        if (!en)
          state_nx = ST_IDLE;
`endif
        if (wrap && (ld.div == '0))
          state_nx = ST_IDLE;
      end
    endcase

    // outputs follow the config that owns the period cnt_nx belongs to
    if (state_nx != ST_IDLE) begin
      clk_nx  = (cnt_nx < act_nx.high);
      tick_nx = (cnt_nx == '0) && (act_nx.high != '0);
    end else begin
      cnt_nx = '0;
    end

    // writes only land while pending is clear, so they never collide with a load
    if (wr) begin
      shd_nx  = {wr_div, wr_high};
      pend_nx = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkdiv_multi.sv
// ---------------------------------------------------------------------------
// clkdiv_multi : CH-channel runtime-programmable clock divider; cfg decode and
//                cfg_ready mux. Build option: CLKDIV_GLITCHFREE_STOP_EN
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter  int CH       = 4,
  parameter  int W        = 16,
  parameter  int DEF_DIV  = CLKDIV_DEF_DIV,
  parameter  int DEF_HIGH = CLKDIV_DEF_HIGH,
  localparam int CW       = ch_sel_width(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic [W-1:0]  cfg_high,
  output logic [CH-1:0] out_clk,
  output logic [CH-1:0] out_tick
);

  logic [CH-1:0]        pending;
  logic [CH-1:0]        wr;
  logic [(1<<CW)-1:0]   pend_pad;

  // unimplemented channel numbers read as never pending, so writes to them are swallowed
  always_comb begin
    pend_pad          = '0;
    pend_pad[CH-1:0]  = pending;
  end

  assign cfg_ready = ~pend_pad[cfg_ch];

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CW'(i));

      clkdiv_channel #(
        .W        (W),
        .DEF_DIV  (DEF_DIV),
        .DEF_HIGH (DEF_HIGH)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en[i]),
        .wr       (wr[i]),
        .wr_div   (cfg_div),
        .wr_high  (cfg_high),
        .pending  (pending[i]),
        .out_clk  (out_clk[i]),
        .out_tick (out_tick[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_multi.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_multi : directed self-checking bench for clkdiv_multi
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clkdiv_multi;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [W-1:0]  cfg_high;
  logic [CH-1:0] out_clk;
  logic [CH-1:0] out_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clkdiv_multi #(
    .CH       (CH),
    .W        (W),
    .DEF_DIV  (16),
    .DEF_HIGH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .out_clk   (out_clk),
    .out_tick  (out_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: after return, the DUT shows the state of the edge just taken
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_high  = '0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n     = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = W'(dv);
    cfg_high  = W'(hi);
    check_eq($sformatf("wr_ready_pre ch%0d", ch), cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check_eq($sformatf("wr_ready_post ch%0d", ch), cfg_ready, 0);
    step();
  endtask

  initial begin
    logic e, t;

    // reset values
    rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    #1;
    check_eq("rst_clk", out_clk, 0);
    check_eq("rst_tick", out_tick, 0);
    check_eq("rst_ready", cfg_ready, 1);
    do_reset();

    // defaults on ch0: 16-cycle period, 8 high
    en = 4'b0001;
    for (int n = 1; n <= 34; n++) begin
      step();
      e = ((n - 1) % 16) < 8;
      t = ((n - 1) % 16) == 0;
      check_eq($sformatf("def_clk c%0d", n), out_clk, {3'b000, e});
      check_eq($sformatf("def_tick c%0d", n), out_tick, {3'b000, t});
    end

    // asynchronous reset mid-period
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_clk", out_clk, 0);
    check_eq("async_rst_tick", out_tick, 0);
    do_reset();

    // ch1 div=5 high=2
    cfg_write(1, 5, 2);
    en = 4'b0010;
    for (int n = 1; n <= 12; n++) begin
      step();
      e = ((n - 1) % 5) < 2;
      t = ((n - 1) % 5) == 0;
      check_eq($sformatf("d5_clk c%0d", n), out_clk, {2'b00, e, 1'b0});
      check_eq($sformatf("d5_tick c%0d", n), out_tick, {2'b00, t, 1'b0});
    end
    do_reset();

    // mid-period write to running ch0, second write held off
    en = 4'b0001;
    for (int n = 1; n <= 4; n++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3; cfg_high = 16'd1;
    check_eq("mid_ready c4", cfg_ready, 1);
    for (int n = 5; n <= 16; n++) begin
      step();
      if (n == 5) begin
        cfg_div  = 16'd7;
        cfg_high = 16'd3;
      end
      e = ((n - 1) % 16) < 8;
      check_eq($sformatf("mid_ready c%0d", n), cfg_ready, 0);
      check_eq($sformatf("mid_old_clk c%0d", n), out_clk[0], e);
    end
    step();
    cfg_valid = 1'b0;
    check_eq("mid_ready c17", cfg_ready, 1);
    check_eq("mid_new_clk c17", out_clk[0], 1);
    check_eq("mid_new_tick c17", out_tick[0], 1);
    for (int n = 18; n <= 25; n++) begin
      step();
      e = ((n - 17) % 3) == 0;
      check_eq($sformatf("mid_new_clk c%0d", n), out_clk[0], e);
      check_eq($sformatf("mid_new_tick c%0d", n), out_tick[0], e);
    end
    do_reset();

    // write accepted on the wrap cycle: old ratio runs one more period
    en = 4'b0001;
    for (int n = 1; n <= 16; n++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4; cfg_high = 16'd2;
    step();
    cfg_valid = 1'b0;
    check_eq("wrapwr_ready c17", cfg_ready, 0);
    for (int n = 17; n <= 40; n++) begin
      if (n > 17) step();
      if (n <= 32) begin
        e = ((n - 1) % 16) < 8;
        t = ((n - 1) % 16) == 0;
      end else begin
        e = ((n - 33) % 4) < 2;
        t = ((n - 33) % 4) == 0;
      end
      check_eq($sformatf("wrapwr_clk c%0d", n), out_clk[0], e);
      check_eq($sformatf("wrapwr_tick c%0d", n), out_tick[0], t);
    end
    do_reset();

    // edge values: ch1 high>div, ch2 div=0, ch3 high=0
    cfg_write(1, 16, 20);
    cfg_write(2, 0, 4);
    cfg_write(3, 6, 0);
    en = 4'b1110;
    for (int n = 1; n <= 33; n++) begin
      step();
      t = ((n - 1) % 16) == 0;
      check_eq($sformatf("edge_clk c%0d", n), out_clk, 4'b0010);
      check_eq($sformatf("edge_tick c%0d", n), out_tick, {2'b00, t, 1'b0});
    end
    // div=1 written to the idle div=0 channel applies immediately
    cfg_write(2, 1, 1);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("div1_clk k%0d", k), out_clk[2], 1);
      check_eq($sformatf("div1_tick k%0d", k), out_tick[2], 1);
      step();
    end
    do_reset();

    // en dropped at cycle 3 with the default 8-high period
    en = 4'b0001;
    for (int n = 1; n <= 3; n++) step();
    en = 4'b0000;
    for (int n = 4; n <= 20; n++) begin
      step();
`ifdef CLKDIV_GLITCHFREE_STOP_EN
      e = (n <= 8);
`else
      e = 1'b0;
`endif
      check_eq($sformatf("stop_clk c%0d", n), out_clk[0], e);
      check_eq($sformatf("stop_tick c%0d", n), out_tick[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
